// File: rtl/doodlejump_soc_pio_pkg.sv
// Shared register map and mode encodings for the doodlejump SoC input PIOs.
// Imported by the PIO top level, its bus interface and the testbench.
package doodlejump_soc_pio_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/doodlejump_soc_edge_pio_if.sv
// Avalon-MM slave bus plus interrupt line for the edge-capture input PIO.
// Latency/backpressure are set by the attached slave; this bundle adds neither.
interface doodlejump_soc_edge_pio_if;
  import doodlejump_soc_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/doodlejump_soc_sync_vec.sv
// WIDTH-wide, STAGES-deep flop synchroniser for asynchronous inputs.
// Latency STAGES cycles; no backpressure (free-running every clock).
module doodlejump_soc_sync_vec #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/doodlejump_soc_edge_pio.sv
// Avalon-MM input PIO: synchronised data, per-bit edge capture (W1C), maskable irq.
// Read latency 1 cycle, irq 1 cycle after capture/mask change; no wait states.
module doodlejump_soc_edge_pio
  import doodlejump_soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_port,
  doodlejump_soc_edge_pio_if.slave   bus
);

  logic [WIDTH-1:0]  sync;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  edge_evt;
  logic [WIDTH-1:0]  irqmask;
  logic [WIDTH-1:0]  edgecap;
  logic [WIDTH-1:0]  edgecap_clr;
  logic [DATA_W-1:0] readdata_nxt;
  logic [DATA_W-1:0] readdata_q;
  logic              irq_nxt;
  logic              irq_q;
  logic              wr_en;
  logic              unused_wdat;

  doodlejump_soc_sync_vec #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (sync)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= sync;
  end

  always_comb begin
    case (EDGE_MODE)
      EDGE_FALL: edge_evt = ~sync & prev;
      EDGE_ANY:  edge_evt = sync ^ prev;
      default:   edge_evt = sync & ~prev;
    endcase
  end

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign edgecap_clr = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  // Upper write-data bits beyond WIDTH carry no state.
  assign unused_wdat = ^bus.writedata;

  // A capture and a clear on the same bit in one cycle keeps the capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr_en && bus.address == ADDR_IRQMASK) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
      edgecap <= (edgecap & ~edgecap_clr) | edge_evt;
    end
  end

  always_comb begin
    readdata_nxt = '0;
    case (bus.address)
      ADDR_DATA:    readdata_nxt[WIDTH-1:0] = sync;
      ADDR_IRQMASK: readdata_nxt[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: readdata_nxt[WIDTH-1:0] = edgecap;
      default:      readdata_nxt = '0;
    endcase
  end

  assign irq_nxt = (IRQ_MODE == IRQ_LEVEL) ? |(sync & irqmask) : |(edgecap & irqmask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_nxt;
      irq_q      <= irq_nxt;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_doodlejump_soc_edge_pio.sv
// Directed bench for doodlejump_soc_edge_pio: three instances cover rising/edge-irq,
// level-irq masking and a 32-bit any-edge configuration.
module tb_doodlejump_soc_edge_pio;
  import doodlejump_soc_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] in_c;
  logic [31:0] v;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  doodlejump_soc_edge_pio_if bus_a ();
  doodlejump_soc_edge_pio_if bus_b ();
  doodlejump_soc_edge_pio_if bus_c ();

  doodlejump_soc_edge_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .IRQ_MODE(IRQ_EDGE))
    u_dut_a (.clk(clk), .reset_n(reset_n), .in_port(in_a), .bus(bus_a));

  doodlejump_soc_edge_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .IRQ_MODE(IRQ_LEVEL))
    u_dut_b (.clk(clk), .reset_n(reset_n), .in_port(in_b), .bus(bus_b));

  doodlejump_soc_edge_pio #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_MODE(EDGE_ANY), .IRQ_MODE(IRQ_EDGE))
    u_dut_c (.clk(clk), .reset_n(reset_n), .in_port(in_c), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_set(input int d, input logic [1:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd);
    case (d)
      0: begin bus_a.address = a; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = wd; end
      1: begin bus_b.address = a; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = wd; end
      default: begin bus_c.address = a; bus_c.chipselect = cs; bus_c.write_n = wn; bus_c.writedata = wd; end
    endcase
  endtask

  function automatic logic [31:0] rdat(input int d);
    case (d)
      0:       return bus_a.readdata;
      1:       return bus_b.readdata;
      default: return bus_c.readdata;
    endcase
  endfunction

  function automatic logic irqv(input int d);
    case (d)
      0:       return bus_a.irq;
      1:       return bus_b.irq;
      default: return bus_c.irq;
    endcase
  endfunction

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] val);
    bus_set(d, a, 1'b1, 1'b0, val);
    tick(1);
    bus_set(d, a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] val);
    bus_set(d, a, 1'b1, 1'b1, 32'h0);
    tick(1);
    val = rdat(d);
  endtask

  initial begin
    reset_n = 1'b0;
    in_a = 8'hFF;
    in_b = 8'h00;
    in_c = 32'h0;
    for (int d = 0; d < 3; d++) bus_set(d, ADDR_DATA, 1'b0, 1'b1, 32'h0);

    // Reset with inputs high
    tick(3);
    chk("rst_readdata", rdat(0), 32'h0);
    chk("rst_irq", {31'h0, irqv(0)}, 32'h0);
    reset_n = 1'b1;
    tick(4);
    chk("post_rst_data", rdat(0), 32'h0000_00FF);
    rd(0, ADDR_EDGECAP, v);
    chk("post_rst_edgecap", v, 32'h0000_00FF);
    chk("post_rst_irq_masked", {31'h0, irqv(0)}, 32'h0);
    in_a = 8'h00;
    tick(4);
    wr(0, ADDR_EDGECAP, 32'hFF);
    rd(0, ADDR_EDGECAP, v);
    chk("w1c_all", v, 32'h0);

    // Rising capture with irq latency SYNC_STAGES+1 edges
    wr(0, ADDR_IRQMASK, 32'h01);
    rd(0, ADDR_IRQMASK, v);
    chk("mask_rb", v, 32'h01);
    in_a = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk($sformatf("irq_lat_%0d", i), {31'h0, irqv(0)}, (i == 4) ? 32'h1 : 32'h0);
    end
    rd(0, ADDR_EDGECAP, v);
    chk("rise_edgecap", v, 32'h01);
    wr(0, ADDR_EDGECAP, 32'h01);
    chk("irq_at_clear", {31'h0, irqv(0)}, 32'h1);
    tick(1);
    chk("irq_after_clear", {31'h0, irqv(0)}, 32'h0);
    rd(0, ADDR_EDGECAP, v);
    chk("edgecap_cleared", v, 32'h0);

    // Collision: new rising edge lands on the same edge as a W1C
    in_a = 8'h00;
    tick(4);
    in_a = 8'h01;
    tick(4);
    in_a = 8'h00;
    tick(4);
    chk("coll_pre_irq", {31'h0, irqv(0)}, 32'h1);
    in_a = 8'h01;
    tick(2);
    wr(0, ADDR_EDGECAP, 32'h01);
    chk("coll_irq0", {31'h0, irqv(0)}, 32'h1);
    tick(1);
    chk("coll_irq1", {31'h0, irqv(0)}, 32'h1);
    rd(0, ADDR_EDGECAP, v);
    chk("coll_edgecap", v, 32'h01);

    // Level interrupt masking
    wr(1, ADDR_IRQMASK, 32'h80);
    in_b = 8'h7F;
    tick(4);
    chk("lvl_7f_irq", {31'h0, irqv(1)}, 32'h0);
    in_b = 8'hFF;
    tick(4);
    chk("lvl_ff_irq", {31'h0, irqv(1)}, 32'h1);
    rd(1, ADDR_DATA, v);
    chk("lvl_data", v, 32'hFF);
    wr(1, ADDR_IRQMASK, 32'h00);
    chk("lvl_irq_at_unmask", {31'h0, irqv(1)}, 32'h1);
    tick(1);
    chk("lvl_irq_unmasked", {31'h0, irqv(1)}, 32'h0);

    // Any-edge on bit 31 of the 32-bit instance
    in_c = 32'h8000_0000;
    tick(2);
    in_c = 32'h0;
    tick(5);
    rd(2, ADDR_EDGECAP, v);
    chk("any_edgecap", v, 32'h8000_0000);
    wr(2, ADDR_DATA, 32'hFFFF_FFFF);
    rd(2, ADDR_DATA, v);
    chk("data_wr_ignored", v, 32'h0);
    in_c = 32'hA5A5_0001;
    tick(4);
    wr(2, ADDR_DATA, 32'h1234_5678);
    rd(2, ADDR_DATA, v);
    chk("data_wide", v, 32'hA5A5_0001);
    wr(2, ADDR_RSVD, 32'hFFFF_FFFF);
    rd(2, ADDR_RSVD, v);
    chk("rsvd_zero", v, 32'h0);
    rd(0, ADDR_RSVD, v);
    chk("rsvd_zero_w8", v, 32'h0);

    // Reset mid-operation
    wr(0, ADDR_IRQMASK, 32'h0F);
    in_a = 8'h0F;
    tick(4);
    rd(0, ADDR_EDGECAP, v);
    chk("mid_edgecap", v, 32'h0F);
    chk("mid_irq", {31'h0, irqv(0)}, 32'h1);
    in_a = 8'h00;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_irq", {31'h0, irqv(0)}, 32'h0);
    chk("mid_rst_rd", rdat(0), 32'h0);
    tick(1);
    reset_n = 1'b1;
    rd(0, ADDR_IRQMASK, v);
    chk("mid_rst_mask", v, 32'h0);
    rd(0, ADDR_EDGECAP, v);
    chk("mid_rst_edgecap", v, 32'h0);
    tick(2);
    chk("mid_rst_irq_after", {31'h0, irqv(0)}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/doodlejump_soc_edge_pio.md
# doodlejump_soc_edge_pio

Parametrised Avalon-MM input port with synchronisation, per-bit edge capture and an interrupt output. It generalises the single-bit, read-only input port to WIDTH bits. It lets the Nios II software in the doodlejump SoC poll or take interrupts on push-buttons, switches and game-status strobes without missing short pulses. The block sits on the Avalon-MM system interconnect as a slave with a 4-word register map.

## Interface
Parameters:
- WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, flops in the input synchroniser (2..4).
- EDGE_MODE, 0, capture edge: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 1, 0 level (data-based), 1 edge (capture-based).

Ports:
- clk  in  1  system clock; one clock domain; everything samples on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low; asserts immediately, deassertion is synchronous to clk.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; bits above WIDTH always 0.
- irq  out  1  registered interrupt request, active-high.

## Operation
Register map:
- Address 0: DATA, read-only, synchronised inputs. Writes are ignored.
- Address 1: reserved; reads 0; writes ignored.
- Address 2: IRQMASK, read/write, WIDTH bits.
- Address 3: EDGECAP, read / write-1-to-clear.

Input path:
- in_port passes through SYNC_STAGES flops to give `sync`, then one more flop to give `prev`.
- Per-bit edge event:
  - EDGE_MODE 0: sync & ~prev.
  - EDGE_MODE 1: ~sync & prev.
  - EDGE_MODE 2: sync ^ prev.
- EDGECAP bit sets on an event and holds until software writes 1 to that bit.
- If an event and a clearing write hit the same bit in the same cycle, the event wins and the bit stays 1.
- Writing 0 to an EDGECAP bit has no effect.

Read path:
- readdata is registered every cycle from the address mux. There is no read strobe, so reads have no side effects.
- Unused upper bits are 0.

Interrupt:
- IRQ_MODE 0: irq_next = |(sync & IRQMASK).
- IRQ_MODE 1: irq_next = |(EDGECAP & IRQMASK).
- irq is the registered irq_next.

Reset:
- readdata = 0, irq = 0, IRQMASK = 0, EDGECAP = 0, all synchroniser flops = 0, prev = 0.
- An asserted input therefore shows a rising event on the first cycles after reset.
- Reset asserted mid-operation clears all state at once. Pending captures are lost.

## Timing
- Let in_port change and be stable before clk edge N.
  - `sync` reflects it after edge N+SYNC_STAGES-1.
  - EDGECAP bit sets at edge N+SYNC_STAGES.
  - irq rises at edge N+SYNC_STAGES+1 (edge mode, mask set).
- Read latency is 1 cycle: address held during cycle k gives the matching readdata after edge k+1.
- Write effect: IRQMASK/EDGECAP update at the edge that samples chipselect=1, write_n=0. A read in the next cycle returns the new value.
- irq deasserts 1 cycle after EDGECAP is cleared or the mask bit is cleared.
- A pulse shorter than one clk period may be missed. A pulse of ≥2 periods is guaranteed to be captured.

## Structure
- Shared package doodlejump_soc_pio_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_MODE encodings: EDGE_RISE, EDGE_FALL, EDGE_ANY;
  - IRQ_MODE encodings: IRQ_LEVEL, IRQ_EDGE.
- One sub-module, doodlejump_soc_sync_vec: a WIDTH-wide, SYNC_STAGES-deep synchroniser chain with asynchronous active-low reset. It is reused by other input PIOs.
- All other logic lives in the top module.

## Test plan
- Reset: hold reset_n=0 with in_port=8'hFF.
  - Required: readdata=0, irq=0.
  - Release reset, read address 0: 8'hFF after SYNC_STAGES+2 cycles.
- Rising capture: WIDTH=8, EDGE_MODE=0, IRQMASK=8'h01, in_port 0→8'h01.
  - Required: EDGECAP reads 8'h01.
  - Required: irq=1 exactly SYNC_STAGES+1 edges after the change.
  - Write 8'h01 to address 3: irq=0 one cycle later; EDGECAP reads 0.
- Collision: a new rising edge on bit 0 reaches EDGECAP in the same cycle as a W1C of 8'h01.
  - Required: EDGECAP bit 0 stays 1; irq stays 1.
- Masking/level: IRQ_MODE=0, IRQMASK=8'h80.
  - Required: in_port=8'h7F gives irq=0.
  - Required: in_port=8'hFF gives irq=1.
  - Required: writing 0 to the mask drops irq in 1 cycle.
- Any-edge and width: WIDTH=32, EDGE_MODE=2, pulse bit 31 high for 2 cycles.
  - Required: EDGECAP=32'h8000_0000 (set on the rise, still set after the fall).
  - Required: writing DATA does not change readdata at address 0.
- Reset mid-operation: EDGECAP=8'h0F, IRQMASK=8'h0F, irq=1, then pulse reset_n low for 1 cycle.
  - Required: irq=0 and EDGECAP=0 immediately; IRQMASK reads 0 after release.
